muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage, alongside the ALU, consuming the decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO operations that ALU control routes away from the ALU. It owns the architectural HI and LO registers. It raises `busy` so the hazard unit stalls the pipeline while an operation is in flight. One radix-2 iteration per cycle.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_divstep.sv | 25 ++
 rtl/muldiv.sv | 161 ++++++++++++++++
 tb/tb_muldiv.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes and decode helpers for the iterative multiply/divide unit.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam logic [2:0] MDOP_MULT  = 3'd0;
    localparam logic [2:0] MDOP_MULTU = 3'd1;
    localparam logic [2:0] MDOP_DIV   = 3'd2;
    localparam logic [2:0] MDOP_DIVU  = 3'd3;
    localparam logic [2:0] MDOP_MTHI  = 3'd4;
    localparam logic [2:0] MDOP_MTLO  = 3'd5;

    function automatic logic op_signed(input logic [2:0] op);
        return (op == MDOP_MULT) || (op == MDOP_DIV);
    endfunction

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == MDOP_MULT) || (op == MDOP_MULTU);
    endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One combinational restoring-divide step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module muldiv_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] prem,
    input  logic             nbit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem,
    output logic             qbit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // prem < divisor, so the shifted value stays below 2*divisor and the
    // sign of the (WIDTH+1)-bit difference is exact.
    always_comb begin
        shifted = {prem, nbit};
        diff    = shifted - {1'b0, divisor};
        qbit    = ~diff[WIDTH];
        rem     = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv.sv
// Iterative radix-2 multiply/divide unit owning HI/LO; busy stalls the pipe.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU are unknown ops.
module muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc, acc_step;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     ua, ub;
    logic [WIDTH:0]       msum;
    logic                 neg_q;
    logic                 op_mul, op_div, op_known, accept, issue, div_zero;

`ifdef MULDIV_DIV_EN
    logic                 is_div, neg_r, dq;
    logic [WIDTH-1:0]     drem;

    assign op_div = (op == MDOP_DIV) || (op == MDOP_DIVU);

    muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
        .prem    (acc[2*WIDTH-1:WIDTH]),
        .nbit    (acc[WIDTH-1]),
        .divisor (mcand),
        .rem     (drem),
        .qbit    (dq)
    );
`else
    assign op_div = 1'b0;
`endif

    assign op_mul   = op_is_mul(op);
    assign op_known = op_mul || op_div || (op == MDOP_MTHI) || (op == MDOP_MTLO);
    assign accept   = (state == IDLE) && start && !abort;
    assign issue    = accept && (op_mul || op_div);
    assign div_zero = op_div && (b == '0);
    assign ua       = (op_signed(op) && a[WIDTH-1]) ? -a : a;
    assign ub       = (op_signed(op) && b[WIDTH-1]) ? -b : b;
    assign busy     = (state != IDLE);

    always_comb begin
        msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_step = {msum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        if (is_div) acc_step = {drem, acc[WIDTH-2:0], dq};
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (issue) state_n = div_zero ? FIX : RUN;
            RUN:     if (cnt == CW'(1)) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            neg_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        cnt   <= CW'(WIDTH);
                        neg_q <= op_signed(op) && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                        is_div <= op_div;
                        neg_r  <= op_signed(op) && a[WIDTH-1];
                        if (div_zero) begin
                            // Raw a lands in HI, all ones in LO, no sign fix.
                            acc    <= {a, {WIDTH{1'b1}}};
                            neg_q  <= 1'b0;
                            neg_r  <= 1'b0;
                        end else if (op_div) begin
                            acc   <= {{WIDTH{1'b0}}, ua};
                            mcand <= ub;
                        end else
`endif
                        begin
                            acc   <= {{WIDTH{1'b0}}, ub};
                            mcand <= ua;
                        end
                    end else if (accept && op == MDOP_MTHI) begin
                        hi <= a;
                    end else if (accept && op == MDOP_MTLO) begin
                        lo <= a;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    if (!abort) begin
                        done <= 1'b1;
`ifdef MULDIV_DIV_EN
                        if (is_div) begin
                            lo <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                            hi <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                        end else
`endif
                        begin
                            {hi, lo} <= neg_q ? -acc : acc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && accept && !op_known)
            $display("[WARNING] muldiv received unknown op %x", op);
    end
`endif

endmodule

// File: tb/tb_muldiv.sv
// Directed self-checking bench for muldiv (WIDTH=32); divide checks follow
// whether MULDIV_DIV_EN is defined for the build.
module tb_muldiv;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        abort = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int failed = 0;

    muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .abort (abort),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive start for cycle 0; returns at the negedge inside cycle 1.
    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int   cyc;
        logic busy_ok;
        issue(o, va, vb);
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, " busy_until_done"}, 64'(busy_ok), 64'd1);
        chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        logic seen_done;

        repeat (2) @(negedge clk);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        reset = 1'b0;

        run_op("mult_neg3x7", MDOP_MULT, 32'hFFFF_FFFD, 32'd7, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max", MDOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_maxpos_minneg", MDOP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 34,
               32'hC000_0000, 32'h8000_0000);

`ifdef MULDIV_DIV_EN
        run_op("div_neg7_2", MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_by0", MDOP_DIVU, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF);
        run_op("div_neg_by0", MDOP_DIV, 32'hFFFF_FFF7, 32'd0, 2, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
        run_op("divu_100_7", MDOP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14);
        run_op("div_7_neg2", MDOP_DIV, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD);
`else
        issue(MDOP_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("nodiv div busy", 64'(busy), 64'd0);
        chk("nodiv div hi", 64'(hi), 64'hC000_0000);
        chk("nodiv div lo", 64'(lo), 64'h8000_0000);
        issue(MDOP_DIVU, 32'd5, 32'd0);
        @(negedge clk);
        chk("nodiv divu busy", 64'(busy), 64'd0);
        chk("nodiv divu done", 64'(done), 64'd0);
        chk("nodiv divu lo", 64'(lo), 64'h8000_0000);
`endif

        issue(MDOP_MTLO, 32'hCAFE_F00D, 32'd0);
        chk("mtlo lo", 64'(lo), 64'hCAFE_F00D);
        chk("mtlo busy", 64'(busy), 64'd0);
        chk("mtlo done", 64'(done), 64'd0);
        issue(MDOP_MTHI, 32'h1234_5678, 32'd0);
        chk("mthi hi", 64'(hi), 64'h1234_5678);
        chk("mthi lo kept", 64'(lo), 64'hCAFE_F00D);

        issue(MDOP_MULT, 32'd2, 32'd3);
        chk("abort busy cyc1", 64'(busy), 64'd1);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy cyc11", 64'(busy), 64'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        chk("abort no done", 64'(seen_done), 64'd0);
        chk("abort hi kept", 64'(hi), 64'h1234_5678);
        chk("abort lo kept", 64'(lo), 64'hCAFE_F00D);

        @(negedge clk);
        start = 1'b1; abort = 1'b1; op = MDOP_MTLO; a = 32'h1111_1111;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort+mtlo lo", 64'(lo), 64'hCAFE_F00D);
        chk("abort+mtlo busy", 64'(busy), 64'd0);

        issue(3'd7, 32'hDEAD_BEEF, 32'd1);
        chk("unknown busy", 64'(busy), 64'd0);
        chk("unknown hi", 64'(hi), 64'h1234_5678);
        chk("unknown lo", 64'(lo), 64'hCAFE_F00D);

        issue(MDOP_MULT, 32'h1234, 32'h5678);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midop reset hi", 64'(hi), 64'd0);
        chk("midop reset lo", 64'(lo), 64'd0);
        chk("midop reset busy", 64'(busy), 64'd0);
        chk("midop reset done", 64'(done), 64'd0);

        run_op("multu_after_reset", MDOP_MULTU, 32'h0001_0000, 32'h0001_0000, 34, 32'd1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
